// File: rtl/demux_1_to_4_stream_pkg.sv
// Shared definitions for the 1-to-4 stream demux and its 4-to-1 select counterpart.
//   NUM_CH / SEL_W   : channel count and select width
//   SLOT_EMPTY/FULL  : per-channel holding slot states
//   decoder_2_to_4() : select -> one-hot channel decode
package demux_1_to_4_stream_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [0:0] SLOT_EMPTY = 1'b0;
    localparam logic [0:0] SLOT_FULL  = 1'b1;

    // 00->ch1 (bit0), 01->ch2 (bit1), 10->ch3 (bit2), 11->ch4 (bit3)
    function automatic logic [NUM_CH-1:0] decoder_2_to_4(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] oh;
        oh = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_1_to_4_stream_if.sv
// Stream bus for the 1-to-4 demux.
//   s, in_data, in_valid, in_ready : producer side, transfer on in_valid & in_ready
//   out_data[n], out_valid[n], out_ready[n] : channel n+1 consumer side
//   xfer_count : accepted input transfers, 8-bit wrapping
// slave  = demux side, master = producer/consumers side.
interface demux_1_to_4_stream_if #(
    parameter int WIDTH = 8
);
    import demux_1_to_4_stream_pkg::*;

    logic [SEL_W-1:0]              s;
    logic [WIDTH-1:0]              in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_CH-1:0][WIDTH-1:0]  out_data;
    logic [NUM_CH-1:0]             out_valid;
    logic [NUM_CH-1:0]             out_ready;
    logic [7:0]                    xfer_count;

    modport slave (
        input  s, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, xfer_count
    );

    modport master (
        output s, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, xfer_count
    );

endinterface

// File: rtl/demux_1_to_4_stream_slot.sv
// stream_slot: one-entry holding register with valid/ready on the output.
//   clk, rst  : clock, synchronous active-high reset
//   load      : write d this edge (caller guarantees room: empty or popping)
//   d         : word to load
//   pop_ready : downstream consumer ready
//   q, valid  : held word and full flag
// Load wins over pop so a simultaneous pop+load keeps the slot full.
module stream_slot
    import demux_1_to_4_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic [0:0] state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SLOT_EMPTY;
            q     <= '0;
        end else if (load) begin
            state <= SLOT_FULL;
            q     <= d;
        end else if (state == SLOT_FULL && pop_ready) begin
            state <= SLOT_EMPTY;
        end
    end

    assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/demux_1_to_4_stream.sv
// demux_1_to_4_stream: registered 1-to-4 stream demultiplexer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of demux_1_to_4_stream_if (input stream, four
//              output channels, transfer counter)
// Each channel owns a one-entry slot, so a stalled consumer only blocks
// the input while it is the selected target.
module demux_1_to_4_stream
    import demux_1_to_4_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    demux_1_to_4_stream_if.slave         bus
);

    logic [NUM_CH-1:0]            tgt;
    logic [NUM_CH-1:0]            room;
    logic [NUM_CH-1:0]            load;
    logic [NUM_CH-1:0][WIDTH-1:0] slot_q;
    logic [NUM_CH-1:0]            slot_vld;
    logic                         accept;
    logic [7:0]                   cnt;

    assign tgt  = decoder_2_to_4(bus.s);
    // A slot can take a word if empty or being drained this same edge.
    assign room = ~slot_vld | bus.out_ready;

    // Ready depends only on the selected slot, never on in_valid.
    assign bus.in_ready = ~rst & |(tgt & room);
    assign accept       = bus.in_valid & bus.in_ready;
    assign load         = {NUM_CH{accept}} & tgt;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_slot
        stream_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[n]),
            .d         (bus.in_data),
            .pop_ready (bus.out_ready[n]),
            .q         (slot_q[n]),
            .valid     (slot_vld[n])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)         cnt <= '0;
        else if (accept) cnt <= cnt + 8'd1;
    end

    assign bus.out_data   = slot_q;
    assign bus.out_valid  = slot_vld;
    assign bus.xfer_count = cnt;

endmodule

// File: tb/tb_demux_1_to_4_stream.sv
// Scoreboard bench for demux_1_to_4_stream: stimulus pushes expected words
// per channel when a transfer is accepted; a negedge monitor pops and
// compares on every output handshake. Directed checks cover reset, stall,
// independence, counter wrap and mid-stream reset.
module tb_demux_1_to_4_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux_1_to_4_stream_if #(.WIDTH(8)) bus ();

    demux_1_to_4_stream #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests  = 0;
    int failed = 0;
    int exp_cnt = 0;
    logic [7:0] sb [4][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; optionally require acceptance in the first cycle.
    task automatic send(input logic [1:0] sel, input logic [7:0] d, input bit imm);
        int n;
        n = 0;
        bus.s        = sel;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(negedge clk);
        if (imm) chk("ready_imm", {31'd0, bus.in_ready}, 32'd1);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            tests++;
            failed++;
            $display("FAIL send_timeout: in_ready 0 after %0d cycles, expected 1", n);
        end else begin
            sb[sel].push_back(d);
            exp_cnt++;
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Monitor: every output handshake must match the head of that channel's queue.
    always @(negedge clk) begin
        if (!rst) begin
            for (int n = 0; n < 4; n++) begin
                if (bus.out_valid[n] && bus.out_ready[n]) begin
                    tests++;
                    if (sb[n].size() == 0) begin
                        failed++;
                        $display("FAIL pop_ch%0d: got word %0h, expected no word", n + 1, bus.out_data[n]);
                    end else begin
                        logic [7:0] e;
                        e = sb[n].pop_front();
                        if (bus.out_data[n] !== e) begin
                            failed++;
                            $display("FAIL pop_ch%0d: got %0h, expected %0h", n + 1, bus.out_data[n], e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.s         = 2'b00;
        bus.in_data   = 8'h99;
        bus.in_valid  = 1'b1;
        bus.out_ready = 4'b0000;

        // Reset held two cycles with a pending offer.
        tick();
        tick();
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {28'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_count", {24'd0, bus.xfer_count}, 32'd0);
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("idle_count", {24'd0, bus.xfer_count}, 32'd0);

        // Fan-out, back-to-back.
        tick();
        bus.out_ready = 4'b1111;
        send(2'b00, 8'h11, 1'b1);
        send(2'b01, 8'h22, 1'b1);
        send(2'b10, 8'h33, 1'b1);
        send(2'b11, 8'h44, 1'b1);
        @(negedge clk);
        chk("fan_valid_last", {28'd0, bus.out_valid}, 32'h8);
        tick();
        @(negedge clk);
        chk("fan_valid_done", {28'd0, bus.out_valid}, 32'h0);
        chk("fan_count", {24'd0, bus.xfer_count}, 32'd4);

        // Backpressure on ch3.
        tick();
        bus.out_ready = 4'b1011;
        send(2'b10, 8'hA5, 1'b1);
        bus.s        = 2'b10;
        bus.in_data  = 8'h5A;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("bp_stall_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_hold_valid", {31'd0, bus.out_valid[2]}, 32'd1);
        chk("bp_hold_data", {24'd0, bus.out_data[2]}, 32'hA5);
        tick();
        @(negedge clk);
        chk("bp_stall_ready2", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_hold_data2", {24'd0, bus.out_data[2]}, 32'hA5);
        tick();
        bus.out_ready = 4'b1111;
        @(negedge clk);
        chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        sb[2].push_back(8'h5A);
        exp_cnt++;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_popload_valid", {31'd0, bus.out_valid[2]}, 32'd1);
        chk("bp_popload_data", {24'd0, bus.out_data[2]}, 32'h5A);
        tick();

        // Independence: ch1 stalled full, ch4 still flows.
        bus.out_ready = 4'b1110;
        send(2'b00, 8'hC3, 1'b1);
        send(2'b11, 8'h77, 1'b1);
        @(negedge clk);
        chk("ind_valid", {28'd0, bus.out_valid}, 32'h9);
        chk("ind_ch1_data", {24'd0, bus.out_data[0]}, 32'hC3);
        chk("ind_ch4_data", {24'd0, bus.out_data[3]}, 32'h77);
        tick();
        bus.out_ready = 4'b1111;
        @(negedge clk);
        chk("ind_count", {24'd0, bus.xfer_count}, exp_cnt[31:0]);
        tick();

        // Counter wrap.
        for (int i = 0; exp_cnt != 255; i++) begin
            logic [31:0] iv;
            iv = i;
            send(iv[1:0], iv[7:0] ^ 8'h3C, 1'b1);
        end
        @(negedge clk);
        chk("count_255", {24'd0, bus.xfer_count}, 32'd255);
        tick();
        send(2'b01, 8'hE1, 1'b1);
        @(negedge clk);
        chk("count_wrap", {24'd0, bus.xfer_count}, 32'd0);
        tick();
        tick();
        @(negedge clk);
        chk("sb_drained", sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size(), 32'd0);
        tick();

        // Mid-operation reset with ch2 full and an offer pending.
        bus.out_ready = 4'b0000;
        send(2'b01, 8'h3C, 1'b1);
        @(negedge clk);
        chk("mid_ch2_full", {31'd0, bus.out_valid[1]}, 32'd1);
        chk("mid_count", {24'd0, bus.xfer_count}, 32'd1);
        tick();
        rst          = 1'b1;
        bus.s        = 2'b00;
        bus.in_data  = 8'hEE;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        for (int n = 0; n < 4; n++) sb[n].delete();
        exp_cnt = 0;
        @(negedge clk);
        chk("mid_valid", {28'd0, bus.out_valid}, 32'h0);
        chk("mid_ch2_data", {24'd0, bus.out_data[1]}, 32'h0);
        chk("mid_count_clr", {24'd0, bus.xfer_count}, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/demux_1_to_4_stream.md
# demux_1_to_4_stream

Registered 1-to-4 stream demultiplexer: accepts one word per cycle on a valid/ready input and delivers it to the output channel chosen by the 2-bit select. Each output channel has its own one-entry holding slot with independent valid/ready. It is the distribution counterpart of the 4-to-1 select path. It sits between a single producer (ALU/bus result) and up to four consumers (register banks, I/O ports) that can stall independently.

## Interface
- WIDTH, default 8: data word width.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous and active-high.
- S  in  2  destination select; 00→ch1, 01→ch2, 10→ch3, 11→ch4; sampled with IN_VALID.
- IN_DATA  in  WIDTH  input word.
- IN_VALID  in  1  producer offers IN_DATA/S this cycle.
- IN_READY  out  1  block accepts this cycle; transfer when IN_VALID & IN_READY.
- OUT_DATA1..OUT_DATA4  out  WIDTH each  per-channel slot contents.
- OUT_VALID  out  4  bit n-1 = channel n slot full.
- OUT_READY  in  4  bit n-1 = channel n consumer accepts; pop when OUT_VALID[n-1] & OUT_READY[n-1].
- XFER_COUNT  out  8  count of accepted input transfers, wraps 255→0.

## Operation
- One-hot target T = decode(S); only slot T is considered for loading.
- IN_READY = ~RST & (~OUT_VALID[T] | OUT_READY[T]); combinational from S, OUT_VALID, OUT_READY; never depends on IN_VALID.
- Per slot n each edge, priority order:
  - RST: valid←0, data←0.
  - load (accept & T==n): data←IN_DATA, valid←1 (covers empty slot and simultaneous pop+load).
  - pop only: valid←0, data unchanged.
  - else hold.
- Slot full and not popped: OUT_DATA/OUT_VALID held stable.
- Stall on target slot does not affect draining of other slots; no head-of-line issue beyond the single input port.
- Producer keeps IN_DATA and S stable while IN_VALID & ~IN_READY. A changed S retargets the stall, is legal, and is not checked.
- XFER_COUNT increments by 1 on every accepted transfer; 8-bit modular.
- Slot states: EMPTY (valid=0), FULL (valid=1). Transitions:
  - EMPTY→FULL on load.
  - FULL→EMPTY on pop without load.
  - FULL→FULL on pop+load or on hold.

## Timing
- Reset values: OUT_VALID=0000, all OUT_DATA=0, XFER_COUNT=0, IN_READY=0 while RST high. IN_READY=1 the first cycle after RST deasserts (all slots empty).
- Latency 1: word accepted at edge k appears on OUT_DATAn with OUT_VALID[n-1]=1 after edge k.
- Throughput: 1 word/cycle sustained to any channel whose consumer holds OUT_READY high, including back-to-back to the same channel.
- RST mid-operation: held words are discarded, and a transfer offered in the RST cycle is not accepted and not counted.
- IN_VALID low: no slot loads and no count change, regardless of S.

## Structure
- Shared header: channel count (4) and select width (2) as defines, reused by the 4-to-1 select path.
- Select decode uses the existing Decoder_2_to_4.
- Sub-module stream_slot (WIDTH param; ports CLK, RST, LOAD, D, POP_READY, Q, VALID), instantiated 4×. The top level holds the decode, the IN_READY mux and XFER_COUNT.

## Test plan
- Reset: assert RST 2 cycles with IN_VALID=1, OUT_READY=0000 → OUT_VALID=0000, OUT_DATA*=0, XFER_COUNT=0, IN_READY=0; after release, IN_READY=1.
- Fan-out: OUT_READY=1111, send 0x11,0x22,0x33,0x44 with S=00,01,10,11 on consecutive cycles → each appears one cycle later on OUT_DATA1..4 with a single-cycle valid pulse; XFER_COUNT=4.
- Backpressure: OUT_READY[2]=0, send 0xA5 to S=10 then 0x5A to S=10 → ch3 holds 0xA5 and IN_READY=0 during the stall. Raise OUT_READY[2] → 0x5A loads on the same edge 0xA5 pops, with OUT_VALID[2] staying 1.
- Independence: ch1 stalled and full; send 0x77 to S=11 → accepted immediately and ch4 valid next cycle; ch1 data unchanged.
- Wrap and mid-reset: 256 accepted transfers → XFER_COUNT=0. With ch2 full, pulse RST while IN_VALID=1 → ch2 cleared and XFER_COUNT=0, no transfer counted.
